// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
// Latency: n/a. Backpressure: n/a.
package cla_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach nib-1; kept at least one bit wide.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_cla.sv
// 4-bit carry-lookahead adder cell.
// Latency: combinational. Backpressure: none.
module cla_seq_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ {c[3:1], ci};
  assign co = c[4];

endmodule

// File: rtl/cla_seq.sv
// Multi-precision add/sub that time-shares one 4-bit CLA cell, LSB nibble first.
// Latency: out_valid rises NIB edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; no accept while busy.
module cla_seq
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
`ifdef USE_POWER_PINS
  inout  wire              vdd,
  inout  wire              vss,
`endif
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB  = WIDTH / NIB_W;
  localparam int IDXW = idx_width(NIB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  res_q;
  logic              cout_q;
  logic              ovf_q;

  logic              accept;
  logic              last_nib;
  logic [IDXW+1:0]   bit_off;
  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [3:0]        sum_nib;
  logic              cla_co;

  assign accept   = in_valid & in_ready;
  assign last_nib = (idx_q == LAST_IDX);
  assign bit_off  = {idx_q, 2'b00};
  assign a_nib    = a_q[bit_off +: NIB_W];
  assign b_nib    = b_q[bit_off +: NIB_W];

  cla_seq_cla u_cla (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (sum_nib),
    .co (cla_co)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Subtraction is A + ~B + 1: invert B once at accept and seed the carry with 1.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          res_q[bit_off +: NIB_W] <= sum_nib;
          carry_q <= cla_co;
          if (last_nib) begin
            idx_q  <= '0;
            cout_q <= cla_co;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nib[3] != a_q[WIDTH-1]);
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_cla_seq.sv
// Self-checking bench for cla_seq: scoreboard of expected results plus
// directed latency, back-pressure, reset and back-to-back scenarios.
module tb_cla_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  cla_seq #(.WIDTH(WIDTH)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int acc_cnt  = 0;
  logic prev_ov = 1'b0;

  // Expected {ovf, cout, result}
  logic [17:0] exp_q[$];
  int          acc_q[$];
  int          acc_hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c);
    logic [15:0] beff;
    logic [16:0] full;
    logic        ov;
    beff = s ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + 17'(s ? 1'b1 : c);
    ov   = (a[15] == beff[15]) && (full[15] != a[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      rise_cnt++;
      check("lat_avail", 32'(acc_q.size() > 0), 1);
      if (acc_q.size() > 0) check("latency", cyc - acc_q.pop_front(), NIB);
    end
    if (!rst && in_valid && in_ready) begin
      acc_q.push_back(cyc + 1);
      acc_hist.push_back(cyc + 1);
      acc_cnt++;
    end
    if (!rst && out_valid && out_ready) begin
      check("sb_avail", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("result", result, e[15:0]);
        check("cout", cout, e[16]);
        check("ovf", ovf, e[17]);
      end
    end
    prev_ov = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    check("accept_wait", in_ready, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    check("idle_wait", busy, 0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c, input logic [17:0] e);
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
    exp_q.push_back(e);
    wait_ready();
    tick();
    in_valid = 1'b0;
    wait_idle();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        c;
    logic [15:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[6] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, {vecs[i].ov, vecs[i].co, vecs[i].r});

    for (int i = 0; i < 12; i++) begin
      logic [15:0] a, b;
      logic s, c;
      a = 16'($urandom); b = 16'($urandom);
      s = 1'($urandom); c = 1'($urandom);
      run_op(a, b, s, c, model(a, b, s, c));
    end

    // Back-pressure: hold the result and offer new operands that must be ignored.
    begin
      int n = 0;
      int acc_before;
      out_ready = 1'b0;
      op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 16'h3333});
      wait_ready();
      tick();
      in_valid = 1'b0;
      while (!out_valid && n < 40) begin tick(); n++; end
      check("bp_done_wait", out_valid, 1);
      acc_before = acc_cnt;
      for (int k = 0; k < 6; k++) begin
        in_valid = 1'b1;
        op_a = 16'($urandom); op_b = 16'($urandom);
        tick();
        check("bp_result", result, 16'h3333);
        check("bp_cout", cout, 0);
        check("bp_ovf", ovf, 0);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      check("bp_no_accept", acc_cnt, acc_before);
      out_ready = 1'b1;
      tick();
      check("bp_release_out_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);
    end

    // Reset with two nibbles processed: partial result discarded.
    begin
      int rc;
      op_a = 16'h00FF; op_b = 16'h0F0F; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      wait_ready();
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("mid_busy", busy, 1);
      rc = rise_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      acc_q.delete();
      check("mr_out_valid", out_valid, 0);
      check("mr_result", result, 0);
      check("mr_in_ready", in_ready, 1);
      check("mr_busy", busy, 0);
      repeat (NIB + 2) tick();
      check("mr_no_pulse", rise_cnt, rc);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002});
    end

    // Back-to-back with in_valid held high.
    op_a = 16'hABCD; op_b = 16'h1111; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
    exp_q.push_back(model(16'hABCD, 16'h1111, 1'b0, 1'b1));
    wait_ready();
    tick();
    op_a = 16'h1000; op_b = 16'h2001; sub = 1'b1; cin = 1'b0;
    exp_q.push_back(model(16'h1000, 16'h2001, 1'b1, 1'b0));
    wait_ready();
    tick();
    in_valid = 1'b0;
    wait_idle();
    check("b2b_spacing", acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2], NIB + 2);

    repeat (2) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
